// File: rtl/rsa_xcel_mont_pkg.sv
// Shared types and message layout for the Montgomery exponentiation accelerator.
// Field positions are given in units of the operand width.
package rsa_xcel_mont_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    SCAN     = 4'd1,
    SQR_REQ  = 4'd2,
    SQR_WAIT = 4'd3,
    MUL_REQ  = 4'd4,
    MUL_WAIT = 4'd5,
    OUT_REQ  = 4'd6,
    OUT_WAIT = 4'd7,
    DONE     = 4'd8
  } state_e;

  // Input message: {r_mont, n, e, b_mont}
  localparam int IN_B_FLD  = 0;
  localparam int IN_E_FLD  = 1;
  localparam int IN_N_FLD  = 2;
  localparam int IN_R_FLD  = 3;

  // Multiplier request: {n, a, b}
  localparam int REQ_B_FLD = 0;
  localparam int REQ_A_FLD = 1;
  localparam int REQ_N_FLD = 2;

  localparam logic [31:0] MONT_ONE_PLAIN = 32'd1;

endpackage

// File: rtl/rsa_xcel_mont_exp_sched.sv
// Left-to-right square-and-multiply scheduler driving one shared Montgomery
// multiplier; the final multiply-by-1 converts the result out of Montgomery form.
module rsa_xcel_mont_exp_sched
  import rsa_xcel_mont_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4*NBITS-1:0] istream_msg,
  input  logic               istream_val,
  output logic               istream_rdy,
  output logic [3*NBITS-1:0] mm_req_msg,
  output logic               mm_req_val,
  input  logic               mm_req_rdy,
  input  logic [NBITS-1:0]   mm_resp_msg,
  input  logic               mm_resp_val,
  output logic               mm_resp_rdy,
  output logic [NBITS-1:0]   ostream_msg,
  output logic               ostream_val,
  input  logic               ostream_rdy
);

  localparam int IDXW = $clog2(NBITS);

  state_e             state_r, state_s;
  logic [NBITS-1:0]   e_r, e_s, n_r, n_s, b_r, b_s, acc_r, acc_s;
  logic [NBITS-1:0]   out_s, opb_s;
  logic [IDXW-1:0]    idx_r, idx_s;
  logic [3*NBITS-1:0] req_s;
  logic [NBITS-1:0]   in_b_s, in_e_s, in_n_s, in_r_s;

  assign in_b_s = istream_msg[IN_B_FLD*NBITS +: NBITS];
  assign in_e_s = istream_msg[IN_E_FLD*NBITS +: NBITS];
  assign in_n_s = istream_msg[IN_N_FLD*NBITS +: NBITS];
  assign in_r_s = istream_msg[IN_R_FLD*NBITS +: NBITS];

  // Next-state and datapath update for the exponentiation sequence.
  always_comb begin
    state_s = state_r;
    e_s     = e_r;
    n_s     = n_r;
    b_s     = b_r;
    acc_s   = acc_r;
    idx_s   = idx_r;
    out_s   = ostream_msg;
    case (state_r)
      IDLE: begin
        if (istream_val && istream_rdy) begin
          e_s = in_e_s;
          n_s = in_n_s;
          b_s = in_b_s;
          if (in_e_s == {NBITS{1'b0}}) begin
            acc_s   = in_r_s;
            state_s = OUT_REQ;
          end else begin
            idx_s   = IDXW'(NBITS-1);
            state_s = SCAN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        // The leading one seeds the accumulator with b directly.
        if (e_r[idx_r]) begin
          acc_s = b_r;
          if (idx_r == {IDXW{1'b0}}) begin
            state_s = OUT_REQ;
          end else begin
            idx_s   = idx_r - IDXW'(1);
            state_s = SQR_REQ;
          end
        end else begin
          idx_s = idx_r - IDXW'(1);
        end
      end
      SQR_REQ: begin
        if (mm_req_rdy) state_s = SQR_WAIT;
        else            state_s = SQR_REQ;
      end
      SQR_WAIT: begin
        if (mm_resp_val) begin
          acc_s = mm_resp_msg;
          if (e_r[idx_r]) begin
            state_s = MUL_REQ;
          end else if (idx_r == {IDXW{1'b0}}) begin
            state_s = OUT_REQ;
          end else begin
            idx_s   = idx_r - IDXW'(1);
            state_s = SQR_REQ;
          end
        end else begin
          state_s = SQR_WAIT;
        end
      end
      MUL_REQ: begin
        if (mm_req_rdy) state_s = MUL_WAIT;
        else            state_s = MUL_REQ;
      end
      MUL_WAIT: begin
        if (mm_resp_val) begin
          acc_s = mm_resp_msg;
          if (idx_r == {IDXW{1'b0}}) begin
            state_s = OUT_REQ;
          end else begin
            idx_s   = idx_r - IDXW'(1);
            state_s = SQR_REQ;
          end
        end else begin
          state_s = MUL_WAIT;
        end
      end
      OUT_REQ: begin
        if (mm_req_rdy) state_s = OUT_WAIT;
        else            state_s = OUT_REQ;
      end
      OUT_WAIT: begin
        if (mm_resp_val) begin
          out_s   = mm_resp_msg;
          state_s = DONE;
        end else begin
          state_s = OUT_WAIT;
        end
      end
      DONE: begin
        if (ostream_rdy) state_s = IDLE;
        else             state_s = DONE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Second multiplier operand and request message for the upcoming state.
  always_comb begin
    opb_s = {NBITS{1'b0}};
    req_s = {(3*NBITS){1'b0}};
    case (state_s)
      SQR_REQ: opb_s = acc_s;
      MUL_REQ: opb_s = b_s;
      OUT_REQ: opb_s = NBITS'(MONT_ONE_PLAIN);
      default: opb_s = {NBITS{1'b0}};
    endcase
    req_s[REQ_N_FLD*NBITS +: NBITS] = n_s;
    req_s[REQ_A_FLD*NBITS +: NBITS] = acc_s;
    req_s[REQ_B_FLD*NBITS +: NBITS] = opb_s;
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      e_r         <= {NBITS{1'b0}};
      n_r         <= {NBITS{1'b0}};
      b_r         <= {NBITS{1'b0}};
      acc_r       <= {NBITS{1'b0}};
      idx_r       <= {IDXW{1'b0}};
      istream_rdy <= 1'b1;
      mm_req_val  <= 1'b0;
      mm_req_msg  <= {(3*NBITS){1'b0}};
      mm_resp_rdy <= 1'b0;
      ostream_val <= 1'b0;
      ostream_msg <= {NBITS{1'b0}};
    end else begin
      state_r     <= state_s;
      e_r         <= e_s;
      n_r         <= n_s;
      b_r         <= b_s;
      acc_r       <= acc_s;
      idx_r       <= idx_s;
      istream_rdy <= (state_s == IDLE);
      mm_req_val  <= (state_s == SQR_REQ) || (state_s == MUL_REQ) || (state_s == OUT_REQ);
      mm_req_msg  <= req_s;
      mm_resp_rdy <= (state_s == SQR_WAIT) || (state_s == MUL_WAIT) || (state_s == OUT_WAIT);
      ostream_val <= (state_s == DONE);
      ostream_msg <= out_s;
    end
  end

endmodule

// File: tb/tb_rsa_xcel_mont_exp_sched.sv
// Scoreboard bench: reference modular arithmetic predicts multiplier requests and
// results; negedge processes model the multiplier and the output sink.
module tb_rsa_xcel_mont_exp_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] istream_msg;
  logic         istream_val, istream_rdy;
  logic [95:0]  mm_req_msg;
  logic         mm_req_val, mm_req_rdy;
  logic [31:0]  mm_resp_msg;
  logic         mm_resp_val, mm_resp_rdy;
  logic [31:0]  ostream_msg;
  logic         ostream_val, ostream_rdy;

  rsa_xcel_mont_exp_sched #(.NBITS(32)) dut (
    .clk(clk), .reset(reset),
    .istream_msg(istream_msg), .istream_val(istream_val), .istream_rdy(istream_rdy),
    .mm_req_msg(mm_req_msg), .mm_req_val(mm_req_val), .mm_req_rdy(mm_req_rdy),
    .mm_resp_msg(mm_resp_msg), .mm_resp_val(mm_resp_val), .mm_resp_rdy(mm_resp_rdy),
    .ostream_msg(ostream_msg), .ostream_val(ostream_val), .ostream_rdy(ostream_rdy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [95:0] exp_req_q[$];
  logic [31:0] exp_res_q[$];
  int req_stall = 0, resp_delay = 0, out_stall = 0;  // negative: random per transaction
  int req_count = 0, exp_cnt = 0;

  function automatic void check(string name, logic [95:0] act, logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // ---------------- reference arithmetic ----------------
  function automatic logic [63:0] mulmod(logic [63:0] a, logic [63:0] b, logic [63:0] n);
    return ((a % n) * (b % n)) % n;
  endfunction

  function automatic logic [63:0] r_inv(logic [31:0] n);
    logic [63:0] inv2, x;
    inv2 = (64'(n) + 64'd1) >> 1;
    x = 64'd1;
    for (int i = 0; i < 32; i++) x = mulmod(x, inv2, 64'(n));
    return x;
  endfunction

  function automatic logic [31:0] mont_mul(logic [31:0] a, logic [31:0] b, logic [31:0] n);
    logic [63:0] t;
    t = mulmod(mulmod(64'(a), 64'(b), 64'(n)), r_inv(n), 64'(n));
    return t[31:0];
  endfunction

  function automatic logic [31:0] pow_mod(logic [31:0] b, logic [31:0] e, logic [31:0] n);
    logic [63:0] r, base;
    r = 64'd1 % 64'(n);
    base = 64'(b) % 64'(n);
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = mulmod(r, base, 64'(n));
      base = mulmod(base, base, 64'(n));
    end
    return r[31:0];
  endfunction

  function automatic int msb_idx(logic [31:0] e);
    for (int i = 31; i >= 0; i--) if (e[i]) return i;
    return 0;
  endfunction

  // Expected multiplier request stream for one exponentiation.
  function automatic void model_requests(logic [31:0] n, logic [31:0] e, logic [31:0] bm, logic [31:0] rm);
    logic [31:0] acc;
    if (e == 32'd0) begin
      exp_req_q.push_back({n, rm, 32'd1});
    end else begin
      acc = bm;
      for (int i = msb_idx(e) - 1; i >= 0; i--) begin
        exp_req_q.push_back({n, acc, acc});
        acc = mont_mul(acc, acc, n);
        if (e[i]) begin
          exp_req_q.push_back({n, acc, bm});
          acc = mont_mul(acc, bm, n);
        end
      end
      exp_req_q.push_back({n, acc, 32'd1});
    end
  endfunction

  // ---------------- multiplier model ----------------
  bit          mm_busy = 1'b0, req_fire = 1'b0, resp_fire = 1'b0;
  int          stall_cnt = 0, cur_stall = 0, delay_cnt = 0;
  logic [95:0] req_held;
  logic [31:0] resp_data;

  always @(negedge clk) begin
    if (reset) begin
      mm_req_rdy = 1'b0; mm_resp_val = 1'b0; mm_resp_msg = 32'd0;
      mm_busy = 1'b0; req_fire = 1'b0; resp_fire = 1'b0; stall_cnt = 0;
    end else begin
      if (resp_fire) begin
        mm_resp_val = 1'b0; mm_busy = 1'b0; resp_fire = 1'b0;
      end
      if (req_fire) begin
        mm_req_rdy = 1'b0; req_fire = 1'b0; mm_busy = 1'b1; stall_cnt = 0;
        resp_data = mont_mul(req_held[63:32], req_held[31:0], req_held[95:64]);
        delay_cnt = (resp_delay < 0) ? int'($urandom_range(0, 4)) : resp_delay;
      end
      if (mm_busy) begin
        check("single outstanding multiply", 96'(mm_req_val), 96'(0));
        if (!mm_resp_val) begin
          if (delay_cnt == 0) begin
            mm_resp_val = 1'b1; mm_resp_msg = resp_data;
          end else begin
            delay_cnt--; mm_resp_msg = $urandom;
          end
        end
        if (mm_resp_val && mm_resp_rdy) resp_fire = 1'b1;
      end else begin
        mm_resp_msg = $urandom;
        check("mm_resp_rdy idle", 96'(mm_resp_rdy), 96'(0));
        if (mm_req_val) begin
          if (stall_cnt == 0) begin
            req_held = mm_req_msg;
            req_count++;
            cur_stall = (req_stall < 0) ? int'($urandom_range(0, 3)) : req_stall;
            if (exp_req_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL mm request: got unexpected %h", mm_req_msg);
            end else begin
              check("mm request", mm_req_msg, exp_req_q.pop_front());
            end
          end else begin
            check("mm_req_msg stable", mm_req_msg, req_held);
          end
          if (stall_cnt >= cur_stall) begin
            mm_req_rdy = 1'b1; req_fire = 1'b1;
          end
          stall_cnt++;
        end else if (stall_cnt > 0) begin
          check("mm_req_val held", 96'(mm_req_val), 96'(1));
          stall_cnt = 0;
        end
      end
    end
  end

  // ---------------- output sink / scoreboard monitor ----------------
  int          out_cnt = 0, out_cur = 0;
  bit          out_fire = 1'b0;
  logic [31:0] out_held;

  always @(negedge clk) begin
    if (reset) begin
      ostream_rdy = 1'b0; out_cnt = 0; out_fire = 1'b0;
    end else if (out_fire) begin
      ostream_rdy = 1'b0; out_fire = 1'b0; out_cnt = 0;
    end else if (ostream_val) begin
      if (out_cnt == 0) begin
        out_held = ostream_msg;
        out_cur = (out_stall < 0) ? int'($urandom_range(0, 4)) : out_stall;
      end else begin
        check("ostream_msg held", 96'(ostream_msg), 96'(out_held));
      end
      check("istream_rdy while output pending", 96'(istream_rdy), 96'(0));
      if (out_cnt >= out_cur) begin
        ostream_rdy = 1'b1; out_fire = 1'b1;
        if (exp_res_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL result: got unexpected %h", ostream_msg);
        end else begin
          check("result", 96'(ostream_msg), 96'(exp_res_q.pop_front()));
        end
      end
      out_cnt++;
    end else if (out_cnt > 0) begin
      check("ostream_val held", 96'(ostream_val), 96'(1));
      out_cnt = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic reset_checks();
    check("reset istream_rdy", 96'(istream_rdy), 96'(1));
    check("reset mm_req_val", 96'(mm_req_val), 96'(0));
    check("reset mm_resp_rdy", 96'(mm_resp_rdy), 96'(0));
    check("reset ostream_val", 96'(ostream_val), 96'(0));
    check("reset ostream_msg", 96'(ostream_msg), 96'(0));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1 reset = 1'b1; istream_val = 1'b0;
    exp_req_q.delete(); exp_res_q.delete();
    @(negedge clk);
    #1 reset_checks();
    reset = 1'b0;
  endtask

  task automatic issue_job(input logic [31:0] b, input logic [31:0] e, input logic [31:0] n);
    logic [63:0] t;
    logic [31:0] rm, bm;
    int cnt;
    t = 64'h1_0000_0000 % 64'(n); rm = t[31:0];
    t = mulmod(64'(b), 64'(rm), 64'(n)); bm = t[31:0];
    model_requests(n, e, bm, rm);
    exp_res_q.push_back(pow_mod(b, e, n));
    exp_cnt = (e == 32'd0) ? 1 : msb_idx(e) + $countones(e);
    req_count = 0;
    @(negedge clk);
    istream_msg = {rm, n, e, bm};
    istream_val = 1'b1;
    cnt = 0;
    while (!istream_rdy && cnt < 3000) begin @(negedge clk); cnt++; end
    if (!istream_rdy) begin
      checks++; errors++;
      $display("FAIL istream accept: timeout, istream_rdy %b expected 1", istream_rdy);
    end
    @(negedge clk);
    istream_val = 1'b0;
  endtask

  task automatic wait_job();
    int cnt = 0;
    while (exp_res_q.size() != 0 && cnt < 5000) begin @(negedge clk); cnt++; end
    if (exp_res_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL job completion: timeout, %0d results pending expected 0", exp_res_q.size());
      pulse_reset();
    end else begin
      @(negedge clk);
      check("mm transaction count", 96'(req_count), 96'(exp_cnt));
      check("mm requests outstanding", 96'(exp_req_q.size()), 96'(0));
    end
  endtask

  task automatic run_job(input logic [31:0] b, input logic [31:0] e, input logic [31:0] n);
    issue_job(b, e, n);
    wait_job();
  endtask

  initial begin
    logic [31:0] rn, rb, re;
    int cnt;
    reset = 1'b1; istream_val = 1'b0; istream_msg = 128'd0;
    repeat (2) @(negedge clk);
    #1 reset_checks();
    reset = 1'b0;

    // Directed, always-ready multiplier and sink
    run_job(32'd2, 32'd5, 32'd13);
    run_job(32'd4, 32'd0, 32'd13);
    run_job(32'd7, 32'd1, 32'd13);
    run_job(32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFB);

    // Backpressure on every interface
    req_stall = 3; resp_delay = 7; out_stall = 5;
    run_job(32'd2, 32'd5, 32'd13);
    run_job(32'd12345, 32'hA5A5_0F0F, 32'hC000_0001);

    // Reset while waiting on the first square
    req_stall = 0; resp_delay = 7; out_stall = 0;
    issue_job(32'd2, 32'd5, 32'd13);
    cnt = 0;
    while (!mm_busy && cnt < 100) begin @(negedge clk); cnt++; end
    repeat (2) @(negedge clk);
    check("mid-job mm_resp_rdy", 96'(mm_resp_rdy), 96'(1));
    pulse_reset();
    resp_delay = 0;
    run_job(32'd2, 32'd5, 32'd13);

    // Randomized jobs with random stalls
    req_stall = -1; resp_delay = -1; out_stall = -1;
    for (int j = 0; j < 14; j++) begin
      rn = $urandom | 32'd1;
      if (rn < 32'd3) rn = 32'd3;
      rb = $urandom % rn;
      case ($urandom_range(0, 3))
        0: re = $urandom;
        1: re = 32'($urandom_range(0, 15));
        2: re = 32'd1 << $urandom_range(0, 31);
        default: re = $urandom | 32'h8000_0000;
      endcase
      run_job(rb, re, rn);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
